aes_core_sequencer: RTL

AES_CORE_SEQUENCER -- requirements
Module: aes_core_sequencer

---
 rtl/aes_core_sequencer_pkg.sv | 17 +
 rtl/aes_core_sequencer_if.sv | 23 ++
 rtl/aes_core_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/aes_core_sequencer_pkg.sv
// Shared AES sequencing types: cipher operation encoding and sequencer state encoding.
package aes_core_sequencer_pkg;

    typedef enum logic {
        AES_ENC = 1'b0,
        AES_DEC = 1'b1
    } aes_op_e;

    // Sparse encoding leaves unused codes that the FSM folds back to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        DKG    = 3'b011,
        FINISH = 3'b101,
        CLEAR  = 3'b110
    } seq_state_e;

endpackage

// File: rtl/aes_core_sequencer_if.sv
// Request/completion handshake between the AES sequencer (master) and the cipher core (slave).
interface aes_core_sequencer_if;

    logic in_valid;
    logic in_ready;
    logic start;
    logic dec_key_gen;
    logic key_clear;
    logic data_out_clear;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid, start, dec_key_gen, key_clear, data_out_clear, out_ready,
        input  in_ready, out_valid
    );

    modport slave (
        input  in_valid, start, dec_key_gen, key_clear, data_out_clear, out_ready,
        output in_ready, out_valid
    );

endinterface

// File: rtl/aes_core_sequencer.sv
// Sequencer between the AES register file and the cipher core: issues start,
// decryption-key-generation and clear requests and tracks output-register ownership.
//
// state  | meaning
// IDLE   | request (clear or start) is presented to the cipher from here
// DKG    | cipher is generating the decryption round key
// FINISH | cipher is processing a data block
// CLEAR  | cipher is wiping key and/or output state
module aes_core_sequencer
    import aes_core_sequencer_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        op_i,
    input  logic                        manual_op_i,
    input  logic                        start_i,
    input  logic                        data_in_full_i,
    input  logic                        key_written_i,
    input  logic                        key_clear_req_i,
    input  logic                        data_out_clear_req_i,
    input  logic                        data_out_read_i,
    aes_core_sequencer_if.master        cipher,
    output logic                        data_in_clear_o,
    output logic                        data_out_we_o,
    output logic                        output_valid_o,
    output logic                        idle_o,
    output logic                        stall_o
);

    seq_state_e state_q;
    logic       start_q;
    logic       key_new_q;
    logic       clr_key_q;
    logic       clr_data_q;
    logic       clr_data_issued_q;
    logic       output_valid_q;

    logic       trigger;
    logic       clear_pend;
    logic       dkg_req;
    logic       fin_ready;
    logic       in_hs;
    logic       out_hs;
    logic       clear_acc;
    logic       start_acc;

    assign trigger    = manual_op_i ? start_q : data_in_full_i;
    assign clear_pend = clr_key_q | clr_data_q;
    assign dkg_req    = (op_i == AES_DEC) & key_new_q;
    assign fin_ready  = ~output_valid_q | data_out_read_i;

    assign in_hs  = cipher.in_valid & cipher.in_ready;
    assign out_hs = cipher.out_valid & cipher.out_ready;

    assign clear_acc = in_hs & clear_pend;
    // A key-generation request does not consume the data, so the trigger stays armed for the reissue.
    assign start_acc = in_hs & ~clear_pend & ~dkg_req;

    assign output_valid_o = output_valid_q;

    always_comb begin
        cipher.in_valid       = 1'b0;
        cipher.start          = 1'b0;
        cipher.dec_key_gen    = 1'b0;
        cipher.key_clear      = 1'b0;
        cipher.data_out_clear = 1'b0;
        cipher.out_ready      = 1'b0;
        data_in_clear_o       = 1'b0;
        data_out_we_o         = 1'b0;
        idle_o                = 1'b0;
        stall_o               = 1'b0;
        case (state_q)
            IDLE: begin
                idle_o = ~trigger & ~clear_pend;
                if (clear_pend) begin
                    cipher.in_valid       = 1'b1;
                    cipher.key_clear      = clr_key_q;
                    cipher.data_out_clear = clr_data_q;
                end else if (trigger) begin
                    cipher.in_valid    = 1'b1;
                    cipher.start       = 1'b1;
                    cipher.dec_key_gen = dkg_req;
                    data_in_clear_o    = cipher.in_ready & ~dkg_req;
                end
            end
            DKG: begin
                cipher.out_ready = 1'b1;
            end
            FINISH: begin
                cipher.out_ready = fin_ready;
                stall_o          = cipher.out_valid & ~fin_ready;
                data_out_we_o    = cipher.out_valid & fin_ready;
            end
            CLEAR: begin
                cipher.out_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            start_q           <= 1'b0;
            key_new_q         <= 1'b0;
            clr_key_q         <= 1'b0;
            clr_data_q        <= 1'b0;
            clr_data_issued_q <= 1'b0;
            output_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        if (clear_pend)   state_q <= CLEAR;
                        else if (dkg_req) state_q <= DKG;
                        else              state_q <= FINISH;
                    end
                end
                DKG, FINISH, CLEAR: begin
                    if (out_hs) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            start_q    <= (start_q & ~start_acc) | start_i;
            clr_key_q  <= (clr_key_q & ~clear_acc) | key_clear_req_i;
            clr_data_q <= (clr_data_q & ~clear_acc) | data_out_clear_req_i;
            if (clear_acc) clr_data_issued_q <= clr_data_q;

            if (key_written_i)                    key_new_q <= 1'b1;
            else if ((state_q == DKG) && out_hs) key_new_q <= 1'b0;

            if (data_out_we_o) begin
                output_valid_q <= 1'b1;
            end else if (data_out_read_i ||
                         ((state_q == CLEAR) && out_hs && clr_data_issued_q)) begin
                output_valid_q <= 1'b0;
            end
        end
    end

endmodule
